// File: rtl/dmem_ctrl_if.sv
// Core-side data bus between the CPU data port and dmem_ctrl.
// The master drives the request and holds it stable while stall_o is high.
interface dmem_ctrl_if #(
  parameter int DATA_W = 32
);
  logic                  ce;
  logic                  we;
  logic [31:0]           addr;
  logic [DATA_W/8-1:0]   sel;
  logic [DATA_W-1:0]     data_i;
  logic [DATA_W-1:0]     data_o;
  logic                  stall_o;

  modport master (output ce, we, addr, sel, data_i, input  data_o, stall_o);
  modport slave  (input  ce, we, addr, sel, data_i, output data_o, stall_o);
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: wait-stated RAM plus NUM_PORTS memory-mapped output registers.
// Optional DMEM_BUSERR_EN: out-of-range accesses are suppressed and flagged on bus_err_o.
module dmem_ctrl #(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter int          WAIT_CYC  = 1,
  parameter int          NUM_PORTS = 4,
  parameter logic [31:0] IO_BASE   = 32'h8000_0000
) (
  input  logic                        clk,
  input  logic                        rst,
  dmem_ctrl_if.slave                  bus,
`ifdef DMEM_BUSERR_EN
  output logic                        bus_err_o,
`endif
  output logic [NUM_PORTS*DATA_W-1:0] gpio_o
);
  localparam int          NB        = DATA_W / 8;
  localparam int          AW        = $clog2(DEPTH);
  localparam int          IW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [31:0] IO_BYTES  = 32'(NUM_PORTS * 4);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]                       state;
  logic [3:0]                       cnt;
  logic [DATA_W-1:0]                mem [DEPTH];
  logic [NUM_PORTS-1:0][DATA_W-1:0] gpio_q;
  logic [DATA_W-1:0]                rd_word;
  logic [31:0]                      io_off;
  logic [IW-1:0]                    io_idx;
  logic [AW-1:0]                    ram_idx;
  logic                             is_io, io_ok, ram_ok, commit;

  assign is_io   = bus.addr >= IO_BASE;
  assign io_off  = bus.addr - IO_BASE;
  assign io_idx  = io_off[2 +: IW];
  assign io_ok   = io_off < IO_BYTES;
  assign ram_idx = bus.addr[2 +: AW];
`ifdef DMEM_BUSERR_EN
  assign ram_ok  = bus.addr < 32'(DEPTH * 4);
`else
  // Upper address bits are simply dropped, so RAM addresses alias modulo DEPTH.
  assign ram_ok  = 1'b1;
`endif

  // The access happens on the edge that leaves ACCESS with the count exhausted.
  assign commit      = (state == ACCESS) && bus.ce && (cnt == 4'd0);
  assign bus.stall_o = rst && bus.ce && (state != DONE);
  assign gpio_o      = gpio_q;

  always_comb begin
    rd_word = '0;
    if (is_io) begin
      if (io_ok) rd_word = gpio_q[io_idx];
    end else if (ram_ok) begin
      rd_word = mem[ram_idx];
    end
  end

  // RAM array has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (commit && bus.we && !is_io && ram_ok)
      for (int b = 0; b < NB; b++)
        if (bus.sel[b]) mem[ram_idx][b*8 +: 8] <= bus.data_i[b*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bus.data_o <= '0;
      gpio_q     <= '0;
`ifdef DMEM_BUSERR_EN
      bus_err_o  <= 1'b0;
`endif
    end else begin
`ifdef DMEM_BUSERR_EN
      bus_err_o <= 1'b0;
`endif
      case (state)
        IDLE: if (bus.ce) begin
          state <= ACCESS;
          cnt   <= 4'(WAIT_CYC);
        end
        ACCESS: begin
          if (!bus.ce) begin
            state <= IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            if (!bus.we) bus.data_o <= rd_word;
            if (bus.we && is_io && io_ok)
              for (int b = 0; b < NB; b++)
                if (bus.sel[b]) gpio_q[io_idx][b*8 +: 8] <= bus.data_i[b*8 +: 8];
`ifdef DMEM_BUSERR_EN
            if (is_io ? !io_ok : !ram_ok) begin
              bus_err_o  <= 1'b1;
              bus.data_o <= '0;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (WAIT_CYC=2, DEPTH=256, NUM_PORTS=2).
module tb_dmem_ctrl;
  localparam logic [31:0] IO = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  logic [63:0] gpio_o;
`ifdef DMEM_BUSERR_EN
  logic bus_err_o;
`endif
  int n_chk = 0;
  int n_fail = 0;
  int ncyc;
  logic [31:0] last_rd;

  dmem_ctrl_if #(.DATA_W(32)) bus ();

  dmem_ctrl #(.DATA_W(32), .DEPTH(256), .WAIT_CYC(2), .NUM_PORTS(2), .IO_BASE(IO)) dut (
    .clk(clk), .rst(rst), .bus(bus),
`ifdef DMEM_BUSERR_EN
    .bus_err_o(bus_err_o),
`endif
    .gpio_o(gpio_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise a request mid-cycle and count stalled cycles; returns in the DONE cycle with ce still high.
  task automatic do_acc(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output int n);
    bus.ce = 1'b1; bus.we = w; bus.addr = a; bus.sel = s; bus.data_i = d;
    n = 0;
    #1;
    while (bus.stall_o === 1'b1 && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic end_acc();
    bus.ce = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = '0; bus.sel = '0; bus.data_i = '0;
    #3;
    chk("rst_stall", 64'(bus.stall_o), 64'd0);
    chk("rst_data", 64'(bus.data_o), 64'd0);
    chk("rst_gpio", gpio_o, 64'd0);
`ifdef DMEM_BUSERR_EN
    chk("rst_err", 64'(bus_err_o), 64'd0);
`endif
    bus.ce = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    do_acc(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, ncyc);
    chk("wr_full_cycles", 64'(ncyc), 64'd4);
    end_acc();
    do_acc(1'b0, 32'h10, 4'h0, 32'h0, ncyc);
    chk("rd_full_cycles", 64'(ncyc), 64'd4);
    chk("rd_full_data", 64'(bus.data_o), 64'hDEADBEEF);
    end_acc();
    chk("data_held_idle", 64'(bus.data_o), 64'hDEADBEEF);

    do_acc(1'b1, 32'h10, 4'b0010, 32'h0000AA00, ncyc); end_acc();
    do_acc(1'b0, 32'h10, 4'h0, 32'h0, ncyc);
    chk("rd_lane1", 64'(bus.data_o), 64'hDEADAAEF);
    end_acc();
    do_acc(1'b1, 32'h14, 4'h0, 32'hFFFFFFFF, ncyc); end_acc();
    do_acc(1'b0, 32'h10, 4'h0, 32'h0, ncyc);
    chk("sel0_other_word", 64'(bus.data_o), 64'hDEADAAEF);
    end_acc();

    do_acc(1'b1, IO + 32'd4, 4'hF, 32'h5, ncyc);
    chk("io_wr_done_gpio", gpio_o, 64'h0000_0005_0000_0000);
    end_acc();
    do_acc(1'b0, IO + 32'd4, 4'h0, 32'h0, ncyc);
    chk("io_rd_port1", 64'(bus.data_o), 64'h5);
    end_acc();
    do_acc(1'b0, IO + 32'd8, 4'h0, 32'h0, ncyc);
    chk("io_rd_beyond", 64'(bus.data_o), 64'h0);
`ifdef DMEM_BUSERR_EN
    chk("io_beyond_err", 64'(bus_err_o), 64'd1);
`endif
    end_acc();
    do_acc(1'b1, IO + 32'd12, 4'hF, 32'hFF, ncyc); end_acc();
    chk("io_wr_beyond_ign", gpio_o, 64'h0000_0005_0000_0000);

    do_acc(1'b1, 32'h0, 4'hF, 32'h11111111, ncyc); end_acc();
    do_acc(1'b1, 32'h400, 4'hF, 32'h77, ncyc);
`ifdef DMEM_BUSERR_EN
    chk("oor_err_pulse", 64'(bus_err_o), 64'd1);
    end_acc();
    chk("oor_err_clear", 64'(bus_err_o), 64'd0);
    do_acc(1'b0, 32'h0, 4'h0, 32'h0, ncyc);
    chk("oor_no_alias", 64'(bus.data_o), 64'h11111111);
`else
    end_acc();
    do_acc(1'b0, 32'h0, 4'h0, 32'h0, ncyc);
    chk("oor_alias", 64'(bus.data_o), 64'h77);
`endif
    end_acc();

    do_acc(1'b1, 32'h20, 4'hF, 32'h1, ncyc); end_acc();
    do_acc(1'b0, 32'h20, 4'h0, 32'h0, ncyc); end_acc();
    last_rd = bus.data_o;
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h20; bus.sel = 4'hF; bus.data_i = 32'h2;
    @(negedge clk);
    bus.ce = 1'b0;
    #1 chk("abort_stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    chk("abort_data_held", 64'(bus.data_o), 64'(last_rd));
    do_acc(1'b0, 32'h20, 4'h0, 32'h0, ncyc);
    chk("abort_cycles", 64'(ncyc), 64'd4);
    chk("abort_no_commit", 64'(bus.data_o), 64'h1);
    end_acc();

    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = 32'h30; bus.sel = 4'hF; bus.data_i = 32'h9;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_gpio", gpio_o, 64'd0);
    chk("rst_mid_stall", 64'(bus.stall_o), 64'd0);
    bus.ce = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    do_acc(1'b0, 32'h10, 4'h0, 32'h0, ncyc);
    chk("post_rst_cycles", 64'(ncyc), 64'd4);
    chk("post_rst_ram_kept", 64'(bus.data_o), 64'hDEADAAEF);
    end_acc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
